// File: rtl/reg_file_circ_if.sv
// Bus between the FIR controller (master) and the circular register file (slave).
// Carries both write ports, both read ports, circular-window control and clear status.
interface reg_file_circ_if #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 4
);
  logic                 we1;
  logic                 we2;
  logic [ADDR_BITS-1:0] wa1;
  logic [ADDR_BITS-1:0] wa2;
  logic [WIDTH-1:0]     wd1;
  logic [WIDTH-1:0]     wd2;
  logic [ADDR_BITS-1:0] a1;
  logic [ADDR_BITS-1:0] a2;
  logic [WIDTH-1:0]     rd1;
  logic [WIDTH-1:0]     rd2;
  logic                 circ_en;
  logic [ADDR_BITS:0]   circ_len;
  logic                 shift;
  logic                 clear;
  logic                 busy;
  logic [ADDR_BITS-1:0] ptr;

  modport master (
    output we1, we2, wa1, wa2, wd1, wd2, a1, a2, circ_en, circ_len, shift, clear,
    input  rd1, rd2, busy, ptr
  );

  modport slave (
    input  we1, we2, wa1, wa2, wd1, wd2, a1, a2, circ_en, circ_len, shift, clear,
    output rd1, rd2, busy, ptr
  );
endinterface

// File: rtl/reg_file_circ.sv
// Dual-write/dual-read register file with optional zero register, circular addressing and a clear sweep.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to matching reads.
module reg_file_circ #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 4,
  parameter bit ZERO_REG  = 1'b1
) (
  input logic            clk,
  input logic            reset_n,
  reg_file_circ_if.slave bus
);

  localparam int DEPTH  = 1 << ADDR_BITS;
  localparam int BASE   = ZERO_REG ? 1 : 0;
  localparam int MAXLEN = DEPTH - BASE;
  localparam int LW     = ADDR_BITS + 1;

  typedef logic [ADDR_BITS-1:0] addr_t;
  typedef logic [LW-1:0]        len_t;
  typedef logic [WIDTH-1:0]     data_t;

  localparam addr_t BASE_A   = addr_t'(BASE);
  localparam addr_t LAST_A   = addr_t'(DEPTH - 1);
  localparam len_t  MAXLEN_L = len_t'(MAXLEN);

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

  data_t  mem_q [DEPTH];
  data_t  mem_d [DEPTH];
  state_t state_q, state_d;
  addr_t  idx_q, idx_d;
  addr_t  ptr_q, ptr_d;
  len_t   len_q, len_d;

  len_t   eff_len;
  logic   busy;

  logic [ADDR_BITS:0] wt1, wt2, rt1, rt2;
  addr_t  wp1, wp2, rp1, rp2;
  logic   wv1, wv2, rv1, rv2;
  data_t  rd1, rd2;

  // Returns {in_window, physical}; the double fold keeps a stale ptr in range after a length change.
  function automatic logic [ADDR_BITS:0] translate(
    input addr_t logical,
    input addr_t p,
    input logic  circ,
    input len_t  len
  );
    len_t sum;
    if (!circ) begin
      return {1'b1, logical};
    end
    if (len_t'(logical) >= len) begin
      return {1'b0, addr_t'(0)};
    end
    sum = len_t'(p) + len_t'(logical);
    if (sum >= len) begin
      sum = sum - len;
    end
    if (sum >= len) begin
      sum = sum - len;
    end
    return {1'b1, addr_t'(sum + len_t'(BASE))};
  endfunction

  always_comb begin
    eff_len = bus.circ_len;
    if (bus.circ_len == '0 || bus.circ_len > MAXLEN_L) begin
      eff_len = MAXLEN_L;
    end
  end

  assign busy     = (state_q == SWEEP);
  assign bus.busy = busy;
  assign bus.ptr  = ptr_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    len_d   = eff_len;

    case (state_q)
      IDLE: begin
        if (bus.clear) begin
          state_d = SWEEP;
          idx_d   = BASE_A;
        end
      end
      SWEEP: begin
        if (bus.clear) begin
          idx_d = BASE_A;
        end else if (idx_q == LAST_A) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + addr_t'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Moving the head decrements so the previous logical L becomes L+1.
    if (!bus.circ_en || eff_len != len_q || (state_q == IDLE && bus.clear)) begin
      ptr_d = '0;
    end else if (bus.shift && !busy) begin
      ptr_d = (ptr_q == '0) ? addr_t'(eff_len - len_t'(1)) : ptr_q - addr_t'(1);
    end
  end

  // Writes translate with the post-shift pointer, reads with the current one.
  always_comb begin
    wt1 = translate(bus.wa1, ptr_d, bus.circ_en, eff_len);
    wt2 = translate(bus.wa2, ptr_d, bus.circ_en, eff_len);
    rt1 = translate(bus.a1,  ptr_q, bus.circ_en, eff_len);
    rt2 = translate(bus.a2,  ptr_q, bus.circ_en, eff_len);

    wp1 = wt1[ADDR_BITS-1:0];
    wp2 = wt2[ADDR_BITS-1:0];
    rp1 = rt1[ADDR_BITS-1:0];
    rp2 = rt2[ADDR_BITS-1:0];

    wv1 = bus.we1 && !busy && wt1[ADDR_BITS] && !(ZERO_REG && wp1 == '0);
    wv2 = bus.we2 && !busy && wt2[ADDR_BITS] && !(ZERO_REG && wp2 == '0);
    rv1 = rt1[ADDR_BITS] && !(ZERO_REG && rp1 == '0);
    rv2 = rt2[ADDR_BITS] && !(ZERO_REG && rp2 == '0);
  end

  always_comb begin
    mem_d = mem_q;
    if (busy) begin
      mem_d[idx_q] = '0;
    end
    if (wv1) begin
      mem_d[wp1] = bus.wd1;
    end
    if (wv2) begin
      mem_d[wp2] = bus.wd2;
    end
  end

  always_comb begin
    rd1 = rv1 ? mem_q[rp1] : '0;
    rd2 = rv2 ? mem_q[rp2] : '0;
`ifdef REG_FILE_BYPASS_EN
    // Port 2 is checked first so it wins, matching the write collision rule.
    if (rv1 && wv2 && wp2 == rp1) begin
      rd1 = bus.wd2;
    end else if (rv1 && wv1 && wp1 == rp1) begin
      rd1 = bus.wd1;
    end
    if (rv2 && wv2 && wp2 == rp2) begin
      rd2 = bus.wd2;
    end else if (rv2 && wv1 && wp1 == rp2) begin
      rd2 = bus.wd1;
    end
`endif
  end

  assign bus.rd1 = rd1;
  assign bus.rd2 = rd2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      len_q   <= '0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: doc/reg_file_circ.md
Name: reg_file_circ

Overview:
- Parametrised successor to the dual-write/dual-read register file.
- Adds an optional hardwired zero register and a circular-buffer addressing mode, so the FIR datapath can use part of the array as a sample delay line with a moving head pointer.
- Adds a sequential clear engine.
- Sits between the FIR controller (addresses, shift, clear) and the MAC datapath (read data).

Parameters:
- WIDTH, 32, data width in bits.
- ADDR_BITS, 4, address width; DEPTH = 2**ADDR_BITS registers.
- ZERO_REG, 1, 1 = physical register 0 reads as 0 and ignores writes; 0 = register 0 is ordinary.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- we1, we2  in  1  write enables, ports 1 and 2.
- wa1, wa2  in  ADDR_BITS  logical write addresses.
- wd1, wd2  in  WIDTH  write data.
- a1, a2  in  ADDR_BITS  logical read addresses.
- rd1, rd2  out  WIDTH  read data, combinational.
- circ_en  in  1  1 = circular addressing mode.
- circ_len  in  ADDR_BITS+1  window length.
- shift  in  1  advance the head pointer by one, pulse.
- clear  in  1  start a clear sweep, pulse.
- busy  out  1  clear sweep in progress.
- ptr  out  ADDR_BITS  current head pointer.

Behaviour:
- Reset (async, reset_n=0): all registers 0, ptr=0, busy=0, FSM=IDLE, len_q=0. rd1/rd2 then read 0.
- Constants:
  - BASE = ZERO_REG ? 1 : 0.
  - MAXLEN = DEPTH-BASE.
  - eff_len = circ_len, or MAXLEN if circ_len==0 or circ_len>MAXLEN.
- Address translation with circ_en=0: physical = logical.
- Address translation with circ_en=1:
  - Logical L < eff_len maps to physical BASE + ((P + L) mod eff_len).
  - Logical L >= eff_len is out of window: reads return 0, writes are dropped.
- Pointer used for translation:
  - Reads use P = current ptr.
  - Writes use P = ptr_next, the post-shift value, so shift plus a write to logical 0 in the same cycle inserts the newest sample at the new head.
- Reads are combinational from the array. Physical 0 with ZERO_REG=1 always reads 0.
- Writes occur at the rising edge when weN=1 and busy=0.
- Writes to physical 0 with ZERO_REG=1 are ignored.
- Both ports writing the same physical register: port 2 wins.
- Shift, when circ_en=1 and busy=0: ptr_next = (ptr==0) ? eff_len-1 : ptr-1. The delay line ages by one, and the previous logical L becomes logical L+1.
- shift with circ_en=0 has no effect.
- ptr is forced to 0 on any cycle where circ_en=0.
- ptr is forced to 0 in the cycle after eff_len differs from len_q. len_q is a registered copy of eff_len.
- Clear FSM:
  - IDLE: clear=1 goes to SWEEP, with idx=BASE and ptr=0.
  - SWEEP: write 0 to physical idx each cycle and set busy=1. At idx==DEPTH-1, go to IDLE.
  - Sweep length is MAXLEN cycles; busy drops in the cycle after the last register is cleared.
- During SWEEP, user writes and shift are ignored, and reads return current array contents.
- clear=1 while in SWEEP restarts the sweep at BASE.
- reset_n low mid-sweep: immediate return to IDLE with all registers 0.
- Width rules:
  - Modulo arithmetic uses ADDR_BITS+1 bits, with no overflow at P+L <= 2*MAXLEN-2.
  - Data is stored unmodified.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If a read's physical address matches an active, non-dropped write in the same cycle, rdN returns that write data; port 2 data has priority.
  - Translation uses the write's ptr_next and the read's ptr, and matching is on physical address.
  - The zero register is never bypassed.
- Undefined: reads see the old value until after the clock edge (write-then-read is a one-cycle path).

Test Plan:
- Dual write/read: we1=we2=1, wa1=1, wa2=2, wd1=10, wd2=20 for one edge, then a1=1, a2=2 -> rd1=10, rd2=20. Then a1=a2=0 -> rd1=rd2=0, including after a write of 0xFFFF_FFFF to address 0.
- Write collision: we1=we2=1, wa1=wa2=5, wd1=0xAA, wd2=0xBB -> reading address 5 gives 0xBB.
- Circular delay line: circ_en=1, circ_len=4; four cycles of shift=1 with we1=1, wa1=0 and wd1=1,2,3,4 -> a1=0..3 read 4,3,2,1, ptr=0. A fifth shift with wd1=5 -> logical 0..3 read 5,4,3,2. Read at a1=4 -> 0.
- Length clamp and change: circ_len=0 and circ_len=20 both behave as length 15. Changing circ_len from 4 to 8 forces ptr=0 on the next cycle.
- Clear: fill registers 1..15 with nonzero values, pulse clear -> busy=1 for 15 cycles, then all reads 0. A write issued while busy is dropped. A clear pulse at sweep cycle 7 restarts the sweep, giving 22 busy cycles total. Asserting reset_n low at cycle 3 -> busy=0 immediately.
- REG_FILE_BYPASS_EN: we1=1, wa1=3, wd1=0x55 with a1=3 in the same cycle -> rd1=0x55 before the edge when defined, old value when undefined.
